// File: rtl/fma_write_packer.sv
// Packs per-lane FMA result words into phrases and phrases into lines, queueing
// completed (or flushed partial) lines with a per-word valid mask.
module fma_write_packer #(
  parameter int FMA_COUNT  = 2,
  parameter int WORD_WIDTH = 16,
  parameter int PHRASES    = 3,
  parameter int DEPTH      = 4
) (
  input  logic                                    clk_in,
  input  logic                                    rst_in,
  input  logic [FMA_COUNT*WORD_WIDTH-1:0]         fma_out,
  input  logic [FMA_COUNT-1:0]                    fma_valid_out,
  output logic [FMA_COUNT-1:0]                    fma_ready_out,
  input  logic                                    flush_in,
  output logic                                    flush_pending_out,
  output logic [FMA_COUNT*WORD_WIDTH*PHRASES-1:0] line_out,
  output logic [FMA_COUNT*PHRASES-1:0]            line_mask_out,
  output logic                                    line_valid,
  input  logic                                    line_ready_in,
  output logic [$clog2(DEPTH+1)-1:0]              fifo_count_out
);

  localparam int LW    = FMA_COUNT * WORD_WIDTH * PHRASES;
  localparam int MW    = FMA_COUNT * PHRASES;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PI_W  = (PHRASES > 1) ? $clog2(PHRASES) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Handshakes: a lane word moves when fma_valid_out[i] && fma_ready_out[i];
  // a line leaves the queue when line_valid && line_ready_in.
  logic [FMA_COUNT-1:0]            lane_full;
  logic [FMA_COUNT*WORD_WIDTH-1:0] lane_data;
  logic [PI_W-1:0]                 phrase_idx;
  logic [LW-1:0]                   asm_line;
  logic [LW-1:0]                   mem_line [DEPTH];
  logic [MW-1:0]                   mem_mask [DEPTH];
  logic [PTR_W-1:0]                wr_ptr;
  logic [PTR_W-1:0]                rd_ptr;
  logic [CNT_W-1:0]                count;

  logic                            queue_full;
  logic                            pop;
  logic                            push;
  logic [FMA_COUNT-1:0]            xfer;
  logic [FMA_COUNT-1:0]            have;
  logic [FMA_COUNT*WORD_WIDTH-1:0] word;
  logic                            last_slot;
  logic                            flush_req;
  logic                            flush_data;
  logic                            flush_exec;
  logic                            commit;
  logic [LW-1:0]                   next_line;
  logic [MW-1:0]                   next_mask;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign queue_full     = (count == CNT_W'(DEPTH));
  assign line_valid     = (count != '0);
  assign pop            = line_valid && line_ready_in;
  assign fma_ready_out  = {FMA_COUNT{!queue_full && !flush_pending_out}} & ~lane_full;
  assign xfer           = fma_valid_out & fma_ready_out;
  assign have           = lane_full | xfer;
  assign last_slot      = (phrase_idx == PI_W'(PHRASES - 1));
  assign flush_req      = flush_in || flush_pending_out;
  assign flush_data     = (|have) || (phrase_idx != '0);
  // An empty flush produces no push, so it may retire on a pop edge of a full queue.
  assign flush_exec     = flush_req && (!queue_full || (pop && !flush_data));
  assign commit         = (&have) && !flush_exec && (!last_slot || !queue_full);
  assign push           = flush_exec ? flush_data : (commit && last_slot);
  assign line_out       = line_valid ? mem_line[rd_ptr] : '0;
  assign line_mask_out  = line_valid ? mem_mask[rd_ptr] : '0;
  assign fifo_count_out = count;

  // Line as it would look after this cycle: committed phrases plus the current slot.
  always_comb begin
    word      = '0;
    next_line = asm_line;
    next_mask = '0;
    for (int i = 0; i < FMA_COUNT; i++) begin
      word[i*WORD_WIDTH +: WORD_WIDTH] = lane_full[i] ? lane_data[i*WORD_WIDTH +: WORD_WIDTH]
                                                      : fma_out[i*WORD_WIDTH +: WORD_WIDTH];
    end
    for (int p = 0; p < PHRASES; p++) begin
      for (int i = 0; i < FMA_COUNT; i++) begin
        if (p < int'(phrase_idx)) begin
          next_mask[p*FMA_COUNT+i] = 1'b1;
        end else if ((p == int'(phrase_idx)) && have[i]) begin
          next_mask[p*FMA_COUNT+i] = 1'b1;
          next_line[(p*FMA_COUNT+i)*WORD_WIDTH +: WORD_WIDTH] = word[i*WORD_WIDTH +: WORD_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      lane_full         <= '0;
      lane_data         <= '0;
      phrase_idx        <= '0;
      asm_line          <= '0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      flush_pending_out <= 1'b0;
    end else begin
      lane_full <= (flush_exec || commit) ? '0 : (lane_full | xfer);
      for (int i = 0; i < FMA_COUNT; i++) begin
        if (xfer[i]) lane_data[i*WORD_WIDTH +: WORD_WIDTH] <= fma_out[i*WORD_WIDTH +: WORD_WIDTH];
      end

      if (flush_exec || (commit && last_slot)) begin
        phrase_idx <= '0;
        asm_line   <= '0;
      end else if (commit) begin
        phrase_idx <= phrase_idx + 1'b1;
        asm_line   <= next_line;
      end

      flush_pending_out <= flush_exec ? 1'b0 : flush_req;

      if (push) begin
        mem_line[wr_ptr] <= next_line;
        mem_mask[wr_ptr] <= next_mask;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fma_write_packer.sv
// Directed, table-driven bench for fma_write_packer (2 lanes x 16 bits, 3 phrases, depth 2).
module tb_fma_write_packer;

  localparam int LW = 96;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fma_data;
  logic [1:0]  fma_valid;
  logic [1:0]  fma_ready;
  logic        flush;
  logic        flush_pending;
  logic [95:0] line;
  logic [5:0]  line_mask;
  logic        line_valid;
  logic        line_ready;
  logic [1:0]  fifo_count;

  always #5 clk = ~clk;

  fma_write_packer #(
    .FMA_COUNT(2), .WORD_WIDTH(16), .PHRASES(3), .DEPTH(2)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .fma_out(fma_data),
    .fma_valid_out(fma_valid),
    .fma_ready_out(fma_ready),
    .flush_in(flush),
    .flush_pending_out(flush_pending),
    .line_out(line),
    .line_mask_out(line_mask),
    .line_valid(line_valid),
    .line_ready_in(line_ready),
    .fifo_count_out(fifo_count)
  );

  typedef struct {
    logic        rst;
    logic [31:0] fma;
    logic [1:0]  vld;
    logic        flush;
    logic        rdy;
    logic [1:0]  e_ready;
    logic        e_valid;
    logic [1:0]  e_cnt;
    logic        e_fp;
    logic [95:0] e_line;
    logic [5:0]  e_mask;
  } vec_t;

  localparam logic [95:0] LA = 96'h0006_0005_0004_0003_0002_0001;
  localparam logic [95:0] LB = 96'h2222_1111_DDDD_CCCC_BBBB_AAAA;
  localparam logic [95:0] LC = 96'h0000_0000_0000_0009_0008_0007;
  localparam logic [95:0] L1 = 96'h0016_0015_0014_0013_0012_0011;
  localparam logic [95:0] L2 = 96'h0026_0025_0024_0023_0022_0021;
  localparam logic [95:0] L3 = 96'h0036_0035_0034_0033_0032_0031;
  localparam logic [95:0] L4 = 96'h0046_0045_0044_0043_0042_0041;
  localparam logic [95:0] L6 = 96'h0066_0065_0064_0063_0062_0061;
  localparam logic [95:0] L7 = 96'h0076_0075_0074_0073_0072_0071;
  localparam logic [95:0] Z  = '0;
  localparam logic [5:0]  MF = 6'b111111;
  localparam logic [5:0]  MZ = 6'b000000;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [LW-1:0] exp_q[$];
  vec_t        tbl[$];

  function automatic vec_t v(input logic r, input logic [31:0] f, input logic [1:0] vl,
                             input logic fl, input logic rd, input logic [1:0] er,
                             input logic ev, input logic [1:0] ec, input logic ef,
                             input logic [95:0] el, input logic [5:0] em);
    vec_t t;
    t.rst = r; t.fma = f; t.vld = vl; t.flush = fl; t.rdy = rd;
    t.e_ready = er; t.e_valid = ev; t.e_cnt = ec; t.e_fp = ef; t.e_line = el; t.e_mask = em;
    return t;
  endfunction

  task automatic check(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check the state visible before the next edge,
  // and score any line that will be popped on that edge.
  task automatic apply(input vec_t t, input string tag);
    logic [LW-1:0] e;
    @(negedge clk);
    rst        = t.rst;
    fma_data   = t.fma;
    fma_valid  = t.vld;
    flush      = t.flush;
    line_ready = t.rdy;
    #1;
    check({tag, ".ready"},     {94'd0, fma_ready},     {94'd0, t.e_ready});
    check({tag, ".valid"},     {95'd0, line_valid},    {95'd0, t.e_valid});
    check({tag, ".count"},     {94'd0, fifo_count},    {94'd0, t.e_cnt});
    check({tag, ".flush_pend"}, {95'd0, flush_pending}, {95'd0, t.e_fp});
    check({tag, ".line"},      line,                   t.e_line);
    check({tag, ".mask"},      {90'd0, line_mask},     {90'd0, t.e_mask});
    if (line_valid && line_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s.sb: popped line %h but none expected", tag, line);
      end else begin
        e = exp_q.pop_front();
        check({tag, ".sb"}, line, e);
      end
    end
  endtask

  initial begin
    rst = 1'b1; fma_data = '0; fma_valid = '0; flush = 1'b0; line_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset.ready", {94'd0, fma_ready}, {94'd0, 2'b11});
    check("reset.valid", {95'd0, line_valid}, Z);
    check("reset.count", {94'd0, fifo_count}, Z);
    check("reset.flush_pend", {95'd0, flush_pending}, Z);
    check("reset.line", line, Z);
    check("reset.mask", {90'd0, line_mask}, Z);

    exp_q = '{LA, LB, LC, L1, L2, L3, L4, L7};

    // full line, pop immediately
    tbl.push_back(v(1'b0, 32'h0002_0001, 2'b11, 1'b0, 1'b1, 2'b11, 1'b0, 2'd0, 1'b0, Z,  MZ));
    tbl.push_back(v(1'b0, 32'h0004_0003, 2'b11, 1'b0, 1'b1, 2'b11, 1'b0, 2'd0, 1'b0, Z,  MZ));
    tbl.push_back(v(1'b0, 32'h0006_0005, 2'b11, 1'b0, 1'b1, 2'b11, 1'b0, 2'd0, 1'b0, Z,  MZ));
    tbl.push_back(v(1'b0, 32'h0000_0000, 2'b00, 1'b0, 1'b1, 2'b11, 1'b1, 2'd1, 1'b0, LA, MF));
    tbl.push_back(v(1'b0, 32'h0000_0000, 2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 2'd0, 1'b0, Z,  MZ));
    // independent lanes, lane0 held off while latched
    tbl.push_back(v(1'b0, 32'h0000_AAAA, 2'b01, 1'b0, 1'b1, 2'b11, 1'b0, 2'd0, 1'b0, Z,  MZ));
    tbl.push_back(v(1'b0, 32'h0000_CCCC, 2'b01, 1'b0, 1'b1, 2'b10, 1'b0, 2'd0, 1'b0, Z,  MZ));
    tbl.push_back(v(1'b0, 32'hBBBB_CCCC, 2'b11, 1'b0, 1'b1, 2'b10, 1'b0, 2'd0, 1'b0, Z,  MZ));
    tbl.push_back(v(1'b0, 32'h0000_CCCC, 2'b01, 1'b0, 1'b1, 2'b11, 1'b0, 2'd0, 1'b0, Z,  MZ));
    tbl.push_back(v(1'b0, 32'hDDDD_0000, 2'b10, 1'b0, 1'b1, 2'b10, 1'b0, 2'd0, 1'b0, Z,  MZ));
    tbl.push_back(v(1'b0, 32'h2222_1111, 2'b11, 1'b0, 1'b1, 2'b11, 1'b0, 2'd0, 1'b0, Z,  MZ));
    tbl.push_back(v(1'b0, 32'h0000_0000, 2'b00, 1'b0, 1'b1, 2'b11, 1'b1, 2'd1, 1'b0, LB, MF));
    tbl.push_back(v(1'b0, 32'h0000_0000, 2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 2'd0, 1'b0, Z,  MZ));
    // partial flush, then empty flush
    tbl.push_back(v(1'b0, 32'h0008_0007, 2'b11, 1'b0, 1'b1, 2'b11, 1'b0, 2'd0, 1'b0, Z,  MZ));
    tbl.push_back(v(1'b0, 32'h0000_0009, 2'b01, 1'b0, 1'b1, 2'b11, 1'b0, 2'd0, 1'b0, Z,  MZ));
    tbl.push_back(v(1'b0, 32'h0000_0000, 2'b00, 1'b1, 1'b1, 2'b10, 1'b0, 2'd0, 1'b0, Z,  MZ));
    tbl.push_back(v(1'b0, 32'h0000_0000, 2'b00, 1'b0, 1'b1, 2'b11, 1'b1, 2'd1, 1'b0, LC, 6'b000111));
    tbl.push_back(v(1'b0, 32'h0000_0000, 2'b00, 1'b1, 1'b1, 2'b11, 1'b0, 2'd0, 1'b0, Z,  MZ));
    tbl.push_back(v(1'b0, 32'h0000_0000, 2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 2'd0, 1'b0, Z,  MZ));
    // fill queue, backpressure, pop with data waiting
    tbl.push_back(v(1'b0, 32'h0012_0011, 2'b11, 1'b0, 1'b0, 2'b11, 1'b0, 2'd0, 1'b0, Z,  MZ));
    tbl.push_back(v(1'b0, 32'h0014_0013, 2'b11, 1'b0, 1'b0, 2'b11, 1'b0, 2'd0, 1'b0, Z,  MZ));
    tbl.push_back(v(1'b0, 32'h0016_0015, 2'b11, 1'b0, 1'b0, 2'b11, 1'b0, 2'd0, 1'b0, Z,  MZ));
    tbl.push_back(v(1'b0, 32'h0022_0021, 2'b11, 1'b0, 1'b0, 2'b11, 1'b1, 2'd1, 1'b0, L1, MF));
    tbl.push_back(v(1'b0, 32'h0024_0023, 2'b11, 1'b0, 1'b0, 2'b11, 1'b1, 2'd1, 1'b0, L1, MF));
    tbl.push_back(v(1'b0, 32'h0026_0025, 2'b11, 1'b0, 1'b0, 2'b11, 1'b1, 2'd1, 1'b0, L1, MF));
    tbl.push_back(v(1'b0, 32'h0032_0031, 2'b11, 1'b0, 1'b0, 2'b00, 1'b1, 2'd2, 1'b0, L1, MF));
    tbl.push_back(v(1'b0, 32'h0032_0031, 2'b11, 1'b0, 1'b1, 2'b00, 1'b1, 2'd2, 1'b0, L1, MF));
    tbl.push_back(v(1'b0, 32'h0032_0031, 2'b11, 1'b0, 1'b0, 2'b11, 1'b1, 2'd1, 1'b0, L2, MF));
    tbl.push_back(v(1'b0, 32'h0000_0000, 2'b00, 1'b0, 1'b1, 2'b11, 1'b1, 2'd1, 1'b0, L2, MF));
    tbl.push_back(v(1'b0, 32'h0034_0033, 2'b11, 1'b0, 1'b0, 2'b11, 1'b0, 2'd0, 1'b0, Z,  MZ));
    tbl.push_back(v(1'b0, 32'h0036_0035, 2'b11, 1'b0, 1'b0, 2'b11, 1'b0, 2'd0, 1'b0, Z,  MZ));
    tbl.push_back(v(1'b0, 32'h0042_0041, 2'b11, 1'b0, 1'b0, 2'b11, 1'b1, 2'd1, 1'b0, L3, MF));
    tbl.push_back(v(1'b0, 32'h0044_0043, 2'b11, 1'b0, 1'b0, 2'b11, 1'b1, 2'd1, 1'b0, L3, MF));
    tbl.push_back(v(1'b0, 32'h0046_0045, 2'b11, 1'b0, 1'b0, 2'b11, 1'b1, 2'd1, 1'b0, L3, MF));
    // flush against a full queue, back-to-back flush pulse, release by pop
    tbl.push_back(v(1'b0, 32'h0000_0000, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 2'd2, 1'b0, L3, MF));
    tbl.push_back(v(1'b0, 32'h0000_0000, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 2'd2, 1'b1, L3, MF));
    tbl.push_back(v(1'b0, 32'h0000_0000, 2'b00, 1'b0, 1'b1, 2'b00, 1'b1, 2'd2, 1'b1, L3, MF));
    tbl.push_back(v(1'b0, 32'h0000_0000, 2'b00, 1'b0, 1'b0, 2'b11, 1'b1, 2'd1, 1'b0, L4, MF));
    tbl.push_back(v(1'b0, 32'h0000_0000, 2'b00, 1'b0, 1'b1, 2'b11, 1'b1, 2'd1, 1'b0, L4, MF));
    tbl.push_back(v(1'b0, 32'h0000_0000, 2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 2'd0, 1'b0, Z,  MZ));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("v%0d", i));

    // reset with one queued line and two committed phrases; next line must be clean
    apply(v(1'b0, 32'h0062_0061, 2'b11, 1'b0, 1'b0, 2'b11, 1'b0, 2'd0, 1'b0, Z,  MZ), "rs0");
    apply(v(1'b0, 32'h0064_0063, 2'b11, 1'b0, 1'b0, 2'b11, 1'b0, 2'd0, 1'b0, Z,  MZ), "rs1");
    apply(v(1'b0, 32'h0066_0065, 2'b11, 1'b0, 1'b0, 2'b11, 1'b0, 2'd0, 1'b0, Z,  MZ), "rs2");
    apply(v(1'b0, 32'h0052_0051, 2'b11, 1'b0, 1'b0, 2'b11, 1'b1, 2'd1, 1'b0, L6, MF), "rs3");
    apply(v(1'b0, 32'h0054_0053, 2'b11, 1'b0, 1'b0, 2'b11, 1'b1, 2'd1, 1'b0, L6, MF), "rs4");
    apply(v(1'b1, 32'h0000_0000, 2'b00, 1'b0, 1'b0, 2'b11, 1'b1, 2'd1, 1'b0, L6, MF), "rs5");
    apply(v(1'b0, 32'h0072_0071, 2'b11, 1'b0, 1'b1, 2'b11, 1'b0, 2'd0, 1'b0, Z,  MZ), "rs6");
    apply(v(1'b0, 32'h0074_0073, 2'b11, 1'b0, 1'b1, 2'b11, 1'b0, 2'd0, 1'b0, Z,  MZ), "rs7");
    apply(v(1'b0, 32'h0076_0075, 2'b11, 1'b0, 1'b1, 2'b11, 1'b0, 2'd0, 1'b0, Z,  MZ), "rs8");
    apply(v(1'b0, 32'h0000_0000, 2'b00, 1'b0, 1'b1, 2'b11, 1'b1, 2'd1, 1'b0, L7, MF), "rs9");
    apply(v(1'b0, 32'h0000_0000, 2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 2'd0, 1'b0, Z,  MZ), "rs10");

    check("sb.leftover", LW'(exp_q.size()), Z);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fma_write_packer.md
FMA_WRITE_PACKER -- requirements
Module: fma_write_packer

Interface
REQ-001 SHALL have parameter FMA_COUNT, default 2: number of FMA result lanes.
REQ-002 SHALL have parameter WORD_WIDTH, default 16: bits per FMA result word.
REQ-003 SHALL have parameter PHRASES, default 3: phrases (one word per lane) per line; LINE_WIDTH = FMA_COUNT*WORD_WIDTH*PHRASES.
REQ-004 SHALL have parameter DEPTH, default 4: completed-line queue depth, at least 1.
REQ-005 SHALL have port clk_in, input, 1: the single clock; all logic on the rising edge.
REQ-006 SHALL have port rst_in, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port fma_out, input, FMA_COUNT*WORD_WIDTH: lane i result at bits [i*WORD_WIDTH +: WORD_WIDTH].
REQ-008 SHALL have port fma_valid_out, input, FMA_COUNT: per-lane result valid.
REQ-009 SHALL have port fma_ready_out, output, FMA_COUNT: per-lane accept; a word transfers when valid and ready are both high.
REQ-010 SHALL have port flush_in, input, 1: single-cycle request to emit the partial line.
REQ-011 SHALL have port flush_pending_out, output, 1: accepted flush not yet executed.
REQ-012 SHALL have port line_out, output, LINE_WIDTH: queue head; phrase p, lane i at bits [(p*FMA_COUNT+i)*WORD_WIDTH +: WORD_WIDTH].
REQ-013 SHALL have port line_mask_out, output, FMA_COUNT*PHRASES: per-word valid mask of the head line, same index order as line_out.
REQ-014 SHALL have port line_valid, output, 1: queue non-empty.
REQ-015 SHALL have port line_ready_in, input, 1: consumer pops the head when line_valid and line_ready_in are high.
REQ-016 SHALL have port fifo_count_out, output, $clog2(DEPTH+1): lines queued.

Function
REQ-017 SHALL hold one latch per lane; lanes arrive independently, in any cycles.
REQ-018 SHALL drive fma_ready_out[i] = !lane_full[i] && !queue_full && !flush_pending_out, combinationally.
REQ-019 SHALL commit a phrase in the cycle where every lane is either latched or transferring; the phrase goes into slot phrase_idx and all lane latches clear on that edge.
REQ-020 SHALL increment phrase_idx on each commit; on commit of slot PHRASES-1 it SHALL push the line with all mask bits set, reset phrase_idx to 0, and zero the line assembly register.
REQ-021 SHALL make a pushed line visible on line_valid and line_out the cycle after the push edge (1-cycle latency).
REQ-022 SHALL on a flush_in pulse set flush_pending_out; the flush executes on the first edge where the queue is not full (the same edge if not full).
REQ-023 SHALL on flush execution include any words transferring that cycle, push the line with committed phrases masked 1, latched-but-uncommitted lane words placed in slot phrase_idx with their own mask bits set, all other words zero and masked 0; then clear phrase_idx, latches and flush_pending_out.
REQ-024 SHALL on flush with no committed phrase and no latched/transferring word push nothing and only clear flush_pending_out.
REQ-025 SHALL treat flush_in while flush_pending_out is high as a no-op.
REQ-026 SHALL permit push and pop on the same edge; fifo_count_out then stays constant; queue_full is evaluated on the pre-edge count.
REQ-027 SHALL keep line_out and line_mask_out stable while line_valid is high and line_ready_in is low.
REQ-028 SHALL ignore line_ready_in when line_valid is low; count never underflows or exceeds DEPTH.
REQ-029 SHALL wrap queue read/write pointers modulo DEPTH.

Reset
REQ-030 SHALL on rst_in high at an edge clear lane latches, phrase_idx, assembly register, queue pointers, fifo_count_out, flush_pending_out; line_valid=0, line_out=0, line_mask_out=0, fma_ready_out all ones the following cycle.
REQ-031 SHALL let reset mid-line or mid-flush discard all partial and queued data with no line emitted.

Verification (FMA_COUNT=2, WORD_WIDTH=16, PHRASES=3, DEPTH=2)
REQ-032 SHALL test: both lanes valid 3 cycles with words (1,2),(3,4),(5,6), line_ready_in=1 -> one cycle later line_valid=1, line_out=0x0006_0005_0004_0003_0002_0001, mask=6'b111111.
REQ-033 SHALL test: lane0 valid alone with 0xAAAA, then lane0 valid again with 0xCCCC -> fma_ready_out[0]=0 and 0xCCCC held off; lane1 then sends 0xBBBB -> phrase 0 = (AAAA,BBBB), fma_ready_out[0]=1 the next cycle.
REQ-034 SHALL test: one full phrase (7,8) then lane0 0x0009 latched, flush_in pulse -> line_out=0x0000_0000_0000_0009_0008_0007, mask=6'b000111.
REQ-035 SHALL test: line_ready_in=0, push 2 full lines -> fifo_count_out=2, fma_ready_out=2'b00; one pop with new lane data valid -> accepted on the next edge, no data lost or reordered.
REQ-036 SHALL test: queue full, flush_in pulse -> flush_pending_out=1 until a pop, flush executes on that edge; back-to-back flush_in ignored.
REQ-037 SHALL test: rst_in asserted after 2 committed phrases and 1 queued line -> line_valid=0, fifo_count_out=0 next cycle; the next full line emits with correct contents.
